// File: rtl/pe_relay_buf_pkg.sv
// rtl/pe_relay_buf_pkg.sv - shared parameters, width helpers and level-update type for the relay buffer
package pe_relay_buf_pkg;

  localparam int WIDTH_DEF  = 130;
  localparam int NUM_CH_DEF = 4;
  localparam int DEPTH_DEF  = 4;

  // Kind of occupancy update a channel performs on a given edge
  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_INC  = 2'd1,
    LVL_DEC  = 2'd2
  } lvl_op_e;

  // Occupancy must represent 0..depth inclusive, hence depth+1 states
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width; depth is a power of two so the pointer wraps naturally
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pe_relay_fifo.sv
// rtl/pe_relay_fifo.sv - one channel: register-array elastic FIFO with valid/ready on both sides
module pe_relay_fifo
  import pe_relay_buf_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int LVL_W = lvl_width(DEPTH),
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full, empty, push, pop;
  lvl_op_e          lvl_op;

  // Handshake decode: full blocks input even when a pop is happening (no ready-through)
  always_comb begin
    full      = (level_q == LVL_W'(DEPTH));
    empty     = (level_q == '0);
    in_ready  = en & ~full;
    out_valid = en & ~empty;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_data  = empty ? '0 : mem_q[rd_ptr_q];
    level     = level_q;
  end

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    lvl_op   = LVL_HOLD;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      lvl_op = LVL_INC;
    end else if (pop && !push) begin
      lvl_op = LVL_DEC;
    end
    case (lvl_op)
      LVL_INC: level_d = level_q + LVL_W'(1);
      LVL_DEC: level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state; reset discards contents by clearing pointers and level only
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array is never cleared; stale words are unreachable after reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pe_relay_buf.sv
// rtl/pe_relay_buf.sv - NUM_CH independent elastic relay channels gated by ap_start
module pe_relay_buf
  import pe_relay_buf_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int NUM_CH = NUM_CH_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int LVL_W  = lvl_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ap_start,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*LVL_W-1:0] level
);

  logic run_q, run_d;
  logic en;

  // run_q keeps every channel closed while reset is held and for the release edge
  always_comb begin
    run_d = 1'b1;
    en    = ap_start & run_q;
  end

  // Out-of-reset flag register
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pe_relay_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .in_data   (in_data[c*WIDTH +: WIDTH]),
      .in_valid  (in_valid[c]),
      .in_ready  (in_ready[c]),
      .out_data  (out_data[c*WIDTH +: WIDTH]),
      .out_valid (out_valid[c]),
      .out_ready (out_ready[c]),
      .level     (level[c*LVL_W +: LVL_W])
    );
  end

endmodule

// File: tb/tb_pe_relay_buf.sv
// tb/tb_pe_relay_buf.sv - directed scoreboard bench for pe_relay_buf
module tb_pe_relay_buf;

  localparam int WIDTH  = 130;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = 3;
  localparam int CW     = NUM_CH * WIDTH;

  typedef logic [WIDTH-1:0] word_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ap_start = 1'b1;
  logic [CW-1:0]     in_data = '0;
  logic [NUM_CH-1:0] in_valid = '0;
  logic [NUM_CH-1:0] in_ready;
  logic [CW-1:0]     out_data;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready = '0;
  logic [NUM_CH*LVL_W-1:0] level;

  int    n_vec = 0;
  int    n_err = 0;
  word_t sb [NUM_CH][$];

  pe_relay_buf #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int c, input word_t v);
    in_data[c*WIDTH +: WIDTH] = v;
  endtask

  function automatic word_t od(input int c);
    return out_data[c*WIDTH +: WIDTH];
  endfunction

  function automatic logic [LVL_W-1:0] lv(input int c);
    return level[c*LVL_W +: LVL_W];
  endfunction

  // Scoreboard: record accepted words, compare each popped word against the oldest one
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      for (int c = 0; c < NUM_CH; c++) sb[c].delete();
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          if (sb[c].size() == 0) chk("pop_without_push", CW'(1), CW'(0));
          else chk($sformatf("pop_data_ch%0d", c), CW'(od(c)), CW'(sb[c].pop_front()));
        end
        if (lv(c) == '0) chk($sformatf("empty_data_zero_ch%0d", c), CW'(od(c)), CW'(0));
        if (in_valid[c] && in_ready[c]) sb[c].push_back(in_data[c*WIDTH +: WIDTH]);
      end
    end
  end

  initial begin
    // 1: reset held with traffic offered
    in_valid = 4'hF;
    repeat (3) tick();
    chk("rst_in_ready", CW'(in_ready), CW'(0));
    chk("rst_out_valid", CW'(out_valid), CW'(0));
    chk("rst_out_data", out_data, CW'(0));
    chk("rst_level", CW'(level), CW'(0));
    reset = 1'b1;
    in_valid = 4'h0;
    tick();
    chk("post_rst_in_ready", CW'(in_ready), CW'(4'hF));
    chk("post_rst_level", CW'(level), CW'(0));

    // 2: single-word latency on ch0
    set_word(0, word_t'(1));
    in_valid[0] = 1'b1;
    #1 chk("lat_before", CW'(out_valid[0]), CW'(0));
    tick();
    in_valid[0] = 1'b0;
    #1;
    chk("lat_valid", CW'(out_valid[0]), CW'(1));
    chk("lat_data", CW'(od(0)), CW'(1));
    chk("lat_level", CW'(lv(0)), CW'(1));
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("lat_drained", CW'(lv(0)), CW'(0));

    // 3: fill ch1, confirm backpressure, drain in order
    for (int i = 0; i < 4; i++) begin
      set_word(1, word_t'(8'h10 + i));
      in_valid[1] = 1'b1;
      tick();
    end
    set_word(1, word_t'(8'hEE));
    #1;
    chk("full_level", CW'(lv(1)), CW'(4));
    chk("full_in_ready", CW'(in_ready[1]), CW'(0));
    tick();
    chk("full_no_push", CW'(lv(1)), CW'(4));
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    #1 chk("full_pop_no_ready_through", CW'(in_ready[1]), CW'(0));
    repeat (4) tick();
    out_ready[1] = 1'b0;
    chk("drain_level", CW'(lv(1)), CW'(0));
    chk("drain_valid", CW'(out_valid[1]), CW'(0));

    // 4: streaming push/pop on ch2 with pointer wrap
    out_ready[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_word(2, word_t'(12'h200 + i));
      in_valid[2] = 1'b1;
      tick();
      chk($sformatf("stream_level_%0d", i), CW'(lv(2)), CW'(1));
    end
    in_valid[2] = 1'b0;
    tick();
    out_ready[2] = 1'b0;
    chk("stream_end_level", CW'(lv(2)), CW'(0));

    // 5: freeze with two words in ch3
    for (int i = 0; i < 2; i++) begin
      set_word(3, word_t'(8'h30 + i));
      in_valid[3] = 1'b1;
      tick();
    end
    ap_start = 1'b0;
    out_ready[3] = 1'b1;
    set_word(3, word_t'(16'hDEAD));
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("frz_out_valid", CW'(out_valid), CW'(0));
      chk("frz_in_ready", CW'(in_ready), CW'(0));
      chk("frz_level", CW'(lv(3)), CW'(2));
      tick();
    end
    in_valid[3] = 1'b0;
    ap_start = 1'b1;
    tick();
    tick();
    out_ready[3] = 1'b0;
    chk("frz_resume_level", CW'(lv(3)), CW'(0));

    // 6: reset mid-stream with ch0 at three words
    for (int i = 0; i < 3; i++) begin
      set_word(0, word_t'(8'hA0 + i));
      in_valid[0] = 1'b1;
      tick();
    end
    in_valid[0] = 1'b0;
    #1 chk("pre_rst_level", CW'(lv(0)), CW'(3));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_level", CW'(level), CW'(0));
    chk("midrst_valid", CW'(out_valid), CW'(0));
    chk("midrst_data", out_data, CW'(0));
    set_word(0, word_t'(8'hAA));
    in_valid[0] = 1'b1;
    for (int k = 0; k < 10 && !(in_valid[0] && in_ready[0]); k++) tick();
    tick();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 10 && !out_valid[0]; k++) tick();
    #1;
    chk("after_rst_valid", CW'(out_valid[0]), CW'(1));
    chk("after_rst_first", CW'(od(0)), CW'(8'hAA));
    out_ready[0] = 1'b1;
    tick();

    // isolation: ch1 stalled full, ch0 at full rate
    for (int i = 0; i < 4; i++) begin
      set_word(1, word_t'(8'h70 + i));
      in_valid[1] = 1'b1;
      tick();
    end
    set_word(1, word_t'(8'h7F));
    for (int i = 0; i < 8; i++) begin
      set_word(0, word_t'(12'h500 + i));
      in_valid[0] = 1'b1;
      tick();
      chk("iso_ch0_level", CW'(lv(0)), CW'(1));
      chk("iso_ch1_level", CW'(lv(1)), CW'(4));
      chk("iso_ch1_ready", CW'(in_ready[1]), CW'(0));
    end
    in_valid = '0;
    tick();
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b1;
    repeat (4) tick();
    out_ready = '0;
    chk("iso_ch1_drained", CW'(lv(1)), CW'(0));
    chk("iso_ch0_drained", CW'(lv(0)), CW'(0));
    tick();
    for (int c = 0; c < NUM_CH; c++) chk($sformatf("sb_empty_ch%0d", c), CW'(sb[c].size()), CW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
